// File: rtl/ex_stage_pkg.sv
// Shared RV32IM pipeline types for the execute stage: control word,
// ID/EX and EX/MEM register layouts, ALU/MD opcodes and branch funct3 codes.
package ex_stage_pkg;

  localparam int RV_XLEN = 32;
  typedef logic [RV_XLEN-1:0] xlen_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SRL    = 4'd3,
    ALU_SRA    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_XOR    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // Encoding follows the M-extension funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic SRC_A_REG = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_REG = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // An all-zero ctrl_t is a bubble
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_a;
    logic    alu_src_b;
    logic    branch;
    logic    jump;
    logic    jalr;
    logic    md_en;
    md_op_e  md_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } ctrl_t;

  typedef struct packed {
    xlen_t      pc;
    xlen_t      instr;
    xlen_t      rs1_data;
    xlen_t      rs2_data;
    xlen_t      imm;
    logic [4:0] rd;
    ctrl_t      ctrl;
  } id_ex_t;

  typedef struct packed {
    xlen_t      pc;
    xlen_t      instr;
    xlen_t      alu_result;
    xlen_t      rs2_data;
    logic [4:0] rd;
    ctrl_t      ctrl;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the execute-stage pipeline signals. The pipeline/hazard side is
// the master, the execute stage is the slave.
interface ex_stage_if;
  import ex_stage_pkg::*;

  id_ex_t     id_ex_in;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  xlen_t      ex_mem_fwd;
  xlen_t      wb_fwd;
  logic       stall;
  logic       flush;
  logic       ex_busy;
  logic       branch_taken;
  xlen_t      branch_target;
  ex_mem_t    ex_mem_out;

  modport master (
    output id_ex_in, fwd_a_sel, fwd_b_sel, ex_mem_fwd, wb_fwd, stall, flush,
    input  ex_busy, branch_taken, branch_target, ex_mem_out
  );

  modport slave (
    input  id_ex_in, fwd_a_sel, fwd_b_sel, ex_mem_fwd, wb_fwd, stall, flush,
    output ex_busy, branch_taken, branch_target, ex_mem_out
  );

endinterface

// File: rtl/ex_stage_md.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one step per cycle, with a sign fix-up at the end.
// Divide-by-zero and INT_MIN/-1 skip the iteration and finish immediately.
module md_unit
  import ex_stage_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            stall,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opd_r;
  md_op_e            op_r;
  logic              is_div_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic [XLEN-1:0]   res_r;

  logic              is_div_s, sgn_a_s, sgn_b_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, fast_res_s;
  logic              div0_s, ovf_s, fast_s;
  logic [XLEN:0]     sum_s, shifted_s;
  logic [XLEN+1:0]   diff_s;
  logic [2*XLEN-1:0] step_s;

  // Select low/high product or signed quotient/remainder after sign correction
  function automatic logic [XLEN-1:0] fix_up(input md_op_e f_op,
                                             input logic [2*XLEN-1:0] f_acc,
                                             input logic f_neg_q,
                                             input logic f_neg_r);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = f_neg_q ? -f_acc : f_acc;
    quo  = f_neg_q ? -f_acc[XLEN-1:0] : f_acc[XLEN-1:0];
    rem  = f_neg_r ? -f_acc[2*XLEN-1:XLEN] : f_acc[2*XLEN-1:XLEN];
    case (f_op)
      MD_MUL:                        fix_up = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_up = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_up = quo;
      default:                       fix_up = rem;
    endcase
  endfunction

  // Decode the incoming op: signedness, magnitudes and fast-path results
  always_comb begin
    is_div_s   = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    sgn_a_s    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    sgn_b_s    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg_s    = sgn_a_s && a[XLEN-1];
    b_neg_s    = sgn_b_s && b[XLEN-1];
    a_mag_s    = a_neg_s ? -a : a;
    b_mag_s    = b_neg_s ? -b : b;
    div0_s     = is_div_s && (b == '0);
    ovf_s      = ((op == MD_DIV) || (op == MD_REM)) &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast_s     = div0_s || ovf_s;
    fast_res_s = '0;
    if (div0_s) begin
      if ((op == MD_DIV) || (op == MD_DIVU)) begin
        fast_res_s = '1;
      end else begin
        fast_res_s = a;
      end
    end else if (ovf_s && (op == MD_DIV)) begin
      fast_res_s = {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      fast_res_s = '0;
    end
  end

  // One shift-add or restoring-divide iteration on the accumulator
  always_comb begin
    sum_s     = '0;
    shifted_s = acc_r[2*XLEN-1:XLEN-1];
    diff_s    = {1'b0, shifted_s} - {2'b00, opd_r};
    step_s    = acc_r;
    if (is_div_r) begin
      if (!diff_s[XLEN+1]) begin
        step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opd_r};
      end else begin
        sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
      end
      step_s = {sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      opd_r    <= '0;
      op_r     <= MD_MUL;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      res_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !flush) begin
            op_r     <= op;
            is_div_r <= is_div_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            cnt_r    <= '0;
            if (fast_s) begin
              res_r   <= fast_res_s;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_BUSY;
              if (is_div_s) begin
                acc_r <= {{XLEN{1'b0}}, a_mag_s};
                opd_r <= b_mag_s;
              end else begin
                acc_r <= {{XLEN{1'b0}}, b_mag_s};
                opd_r <= a_mag_s;
              end
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state_r <= ST_IDLE;
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == LAST_CNT) begin
              res_r   <= fix_up(op_r, step_s, neg_q_r, neg_r_r);
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (flush || !stall) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy   = ((state_r == ST_IDLE) && start) || (state_r == ST_BUSY);
  assign done   = (state_r == ST_DONE);
  assign result = res_r;

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding, ALU, branch/jump resolution,
// iterative M-extension unit and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int XLEN     = RV_XLEN
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  id_ex_t     id_s;
  xlen_t      opa_fwd_s, opb_fwd_s, op_a_s, op_b_s;
  xlen_t      alu_res_s, result_s, jalr_sum_s, br_target_s;
  logic [4:0] shamt_s;
  logic       br_cond_s, take_s;
  logic       md_start_s, md_busy_s, md_done_s;
  xlen_t      md_result_s;
  ex_mem_t    ex_mem_next_s, ex_mem_r;

  assign id_s = bus.id_ex_in;

  // Forwarding muxes and ALU source selection
  always_comb begin
    opa_fwd_s = id_s.rs1_data;
    opb_fwd_s = id_s.rs2_data;
    case (bus.fwd_a_sel)
      FWD_MEM: opa_fwd_s = bus.ex_mem_fwd;
      FWD_WB:  opa_fwd_s = bus.wb_fwd;
      default: opa_fwd_s = id_s.rs1_data;
    endcase
    case (bus.fwd_b_sel)
      FWD_MEM: opb_fwd_s = bus.ex_mem_fwd;
      FWD_WB:  opb_fwd_s = bus.wb_fwd;
      default: opb_fwd_s = id_s.rs2_data;
    endcase
    if (id_s.ctrl.alu_src_a == SRC_A_PC) begin
      op_a_s = id_s.pc;
    end else begin
      op_a_s = opa_fwd_s;
    end
    if (id_s.ctrl.alu_src_b == SRC_B_IMM) begin
      op_b_s = id_s.imm;
    end else begin
      op_b_s = opb_fwd_s;
    end
  end

  // Integer ALU
  always_comb begin
    shamt_s   = op_b_s[4:0];
    alu_res_s = '0;
    case (id_s.ctrl.alu_op)
      ALU_ADD:    alu_res_s = op_a_s + op_b_s;
      ALU_SUB:    alu_res_s = op_a_s - op_b_s;
      ALU_SLL:    alu_res_s = op_a_s << shamt_s;
      ALU_SRL:    alu_res_s = op_a_s >> shamt_s;
      ALU_SRA:    alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
      ALU_SLT:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      ALU_SLTU:   alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      ALU_XOR:    alu_res_s = op_a_s ^ op_b_s;
      ALU_OR:     alu_res_s = op_a_s | op_b_s;
      ALU_AND:    alu_res_s = op_a_s & op_b_s;
      ALU_PASS_B: alu_res_s = op_b_s;
      default:    alu_res_s = '0;
    endcase
  end

  // Branch condition and redirect target; compares use the forwarded registers
  always_comb begin
    case (id_s.instr[14:12])
      F3_BEQ:  br_cond_s = (opa_fwd_s == opb_fwd_s);
      F3_BNE:  br_cond_s = (opa_fwd_s != opb_fwd_s);
      F3_BLT:  br_cond_s = ($signed(opa_fwd_s) < $signed(opb_fwd_s));
      F3_BGE:  br_cond_s = ($signed(opa_fwd_s) >= $signed(opb_fwd_s));
      F3_BLTU: br_cond_s = (opa_fwd_s < opb_fwd_s);
      F3_BGEU: br_cond_s = (opa_fwd_s >= opb_fwd_s);
      default: br_cond_s = 1'b0;
    endcase
    jalr_sum_s = opa_fwd_s + id_s.imm;
    if (id_s.ctrl.jalr) begin
      br_target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else begin
      br_target_s = id_s.pc + id_s.imm;
    end
    // A redirect must not fire while EX is frozen or the M unit owns the slot
    take_s = (id_s.ctrl.jump || (id_s.ctrl.branch && br_cond_s)) &&
             !bus.stall && !md_busy_s;
  end

  assign md_start_s = id_s.ctrl.md_en && ENABLE_M;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .flush  (bus.flush),
    .stall  (bus.stall),
    .op     (id_s.ctrl.md_op),
    .a      (opa_fwd_s),
    .b      (opb_fwd_s),
    .busy   (md_busy_s),
    .done   (md_done_s),
    .result (md_result_s)
  );

  // Result selection and next EX/MEM contents
  always_comb begin
    if (id_s.ctrl.jump) begin
      result_s = id_s.pc + XLEN'(4);
    end else if (id_s.ctrl.md_en) begin
      if (ENABLE_M && md_done_s) begin
        result_s = md_result_s;
      end else begin
        result_s = '0;
      end
    end else begin
      result_s = alu_res_s;
    end
    ex_mem_next_s            = '0;
    ex_mem_next_s.pc         = id_s.pc;
    ex_mem_next_s.instr      = id_s.instr;
    ex_mem_next_s.alu_result = result_s;
    ex_mem_next_s.rs2_data   = opb_fwd_s;
    ex_mem_next_s.rd         = id_s.rd;
    ex_mem_next_s.ctrl       = id_s.ctrl;
  end

  // EX/MEM register: reset, flush, stall-hold, M-busy bubble, capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_r <= '0;
    end else if (bus.flush) begin
      ex_mem_r <= '0;
    end else if (bus.stall) begin
      ex_mem_r <= ex_mem_r;
    end else if (md_busy_s) begin
      ex_mem_r <= '0;
    end else begin
      ex_mem_r <= ex_mem_next_s;
    end
  end

  assign bus.ex_busy       = md_busy_s;
  assign bus.branch_taken  = take_s;
  assign bus.branch_target = br_target_s;
  assign bus.ex_mem_out    = ex_mem_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/branch vector table plus hand-written
// multi-cycle sequences for the multiply/divide unit.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    alu_op_e    op;
    logic       sa, sb, br, jp, jr;
    logic [2:0] f3;
    xlen_t      pc, rs1, rs2, imm;
    logic [1:0] fa, fb;
    xlen_t      mf, wf;
    logic       exp_tk;
    xlen_t      exp_tgt, exp_res, exp_rs2;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    bus.id_ex_in   = '0;
    bus.fwd_a_sel  = 2'b00;
    bus.fwd_b_sel  = 2'b00;
    bus.ex_mem_fwd = '0;
    bus.wb_fwd     = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_ex_t d;
    d                = '0;
    d.pc             = v.pc;
    d.instr          = {17'd0, v.f3, 12'd0};
    d.rs1_data       = v.rs1;
    d.rs2_data       = v.rs2;
    d.imm            = v.imm;
    d.rd             = 5'd3;
    d.ctrl.alu_op    = v.op;
    d.ctrl.alu_src_a = v.sa;
    d.ctrl.alu_src_b = v.sb;
    d.ctrl.branch    = v.br;
    d.ctrl.jump      = v.jp;
    d.ctrl.jalr      = v.jr;
    d.ctrl.reg_write = v.jp | ~v.br;
    bus.id_ex_in     = d;
    bus.fwd_a_sel    = v.fa;
    bus.fwd_b_sel    = v.fb;
    bus.ex_mem_fwd   = v.mf;
    bus.wb_fwd       = v.wf;
  endtask

  task automatic drive_md(input md_op_e op, input xlen_t a, input xlen_t b);
    id_ex_t d;
    d                = '0;
    d.pc             = 32'h0000_0800;
    d.rs1_data       = a;
    d.rs2_data       = b;
    d.rd             = 5'd5;
    d.ctrl.md_en     = 1'b1;
    d.ctrl.md_op     = op;
    d.ctrl.reg_write = 1'b1;
    bus.id_ex_in     = d;
    bus.fwd_a_sel    = 2'b00;
    bus.fwd_b_sel    = 2'b00;
  endtask

  // Count busy cycles (bounded), check bubbles while busy, then the captured result
  task automatic run_md(input string nm, input md_op_e op, input xlen_t a,
                        input xlen_t b, input xlen_t exp, input int exp_cyc);
    int   n;
    logic bub_ok;
    n      = 0;
    bub_ok = 1'b1;
    drive_md(op, a, b);
    #1;
    while (bus.ex_busy && n < 100) begin
      if (n > 0 && bus.ex_mem_out != '0) bub_ok = 1'b0;
      n++;
      tick();
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_bubbles"}, {31'd0, bub_ok}, 32'd1);
    tick();
    chk({nm, "_result"}, bus.ex_mem_out.alu_result, exp);
    chk({nm, "_rd"}, {27'd0, bus.ex_mem_out.rd}, 32'd5);
    drive_bubble();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // name op sa sb br jp jr f3 pc rs1 rs2 imm fa fb mf wf tk tgt res rs2
    vecs[0]  = '{"add_fwd", ALU_ADD, 0, 1, 0, 0, 0, 3'd0, 32'h0, 32'h999, 32'h55, 32'h22, 2'b01, 2'b10, 32'h10, 32'h7, 0, 32'h0, 32'h32, 32'h7};
    vecs[1]  = '{"sub", ALU_SUB, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h5, 32'h7, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'hFFFF_FFFE, 32'h7};
    vecs[2]  = '{"sll", ALU_SLL, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h1, 32'h24, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h10, 32'h24};
    vecs[3]  = '{"srl", ALU_SRL, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h8000_0000, 32'd31, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h1, 32'd31};
    vecs[4]  = '{"sra", ALU_SRA, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h8000_0000, 32'd4, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'hF800_0000, 32'd4};
    vecs[5]  = '{"slt", ALU_SLT, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h1, 32'h1};
    vecs[6]  = '{"sltu", ALU_SLTU, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h1};
    vecs[7]  = '{"xor", ALU_XOR, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'hFF00, 32'h0FF0};
    vecs[8]  = '{"or", ALU_OR, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'hF000, 32'h000F, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'hF00F, 32'h000F};
    vecs[9]  = '{"and", ALU_AND, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'hFF00, 32'h0FF0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h0F00, 32'h0FF0};
    vecs[10] = '{"lui", ALU_PASS_B, 0, 1, 0, 0, 0, 3'd0, 32'h0, 32'h9, 32'h3, 32'h1234_5000, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h1234_5000, 32'h3};
    vecs[11] = '{"auipc", ALU_ADD, 1, 1, 0, 0, 0, 3'd0, 32'h400, 32'h9, 32'h0, 32'h10, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h0, 32'h410, 32'h0};
    vecs[12] = '{"blt", ALU_ADD, 0, 0, 1, 0, 0, F3_BLT, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h120, 32'h0, 32'h1};
    vecs[13] = '{"bltu", ALU_ADD, 0, 0, 1, 0, 0, F3_BLTU, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h120, 32'h0, 32'h1};
    vecs[14] = '{"beq", ALU_ADD, 0, 0, 1, 0, 0, F3_BEQ, 32'h200, 32'h7, 32'h7, 32'hFFFF_FFF0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h1F0, 32'hE, 32'h7};
    vecs[15] = '{"bne", ALU_ADD, 0, 0, 1, 0, 0, F3_BNE, 32'h200, 32'h7, 32'h7, 32'hFFFF_FFF0, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h1F0, 32'hE, 32'h7};
    vecs[16] = '{"bge", ALU_ADD, 0, 0, 1, 0, 0, F3_BGE, 32'h300, 32'h1, 32'hFFFF_FFFF, 32'h8, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h308, 32'h0, 32'hFFFF_FFFF};
    vecs[17] = '{"bgeu", ALU_ADD, 0, 0, 1, 0, 0, F3_BGEU, 32'h300, 32'h1, 32'hFFFF_FFFF, 32'h8, 2'b00, 2'b00, 32'h0, 32'h0, 0, 32'h308, 32'h0, 32'hFFFF_FFFF};
    vecs[18] = '{"jal", ALU_ADD, 1, 1, 0, 1, 0, 3'd0, 32'h1000, 32'h0, 32'h0, 32'h40, 2'b00, 2'b00, 32'h0, 32'h0, 1, 32'h1040, 32'h1004, 32'h0};
    vecs[19] = '{"jalr", ALU_ADD, 0, 1, 0, 1, 1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h0, 2'b01, 2'b00, 32'h203, 32'h0, 1, 32'h202, 32'h504, 32'h0};

    drive_bubble();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    chk("reset_exmem_zero", 32'(bus.ex_mem_out == '0), 32'd1);
    chk("reset_busy", {31'd0, bus.ex_busy}, 32'd0);
    chk("reset_taken", {31'd0, bus.branch_taken}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven ALU / branch / jump vectors
    for (int i = 0; i < 20; i++) begin
      drive_vec(vecs[i]);
      #1;
      chk({vecs[i].name, "_taken"}, {31'd0, bus.branch_taken}, {31'd0, vecs[i].exp_tk});
      if (vecs[i].br || vecs[i].jp)
        chk({vecs[i].name, "_target"}, bus.branch_target, vecs[i].exp_tgt);
      tick();
      chk({vecs[i].name, "_result"}, bus.ex_mem_out.alu_result, vecs[i].exp_res);
      chk({vecs[i].name, "_rs2"}, bus.ex_mem_out.rs2_data, vecs[i].exp_rs2);
    end

    // Stall suppresses the redirect and holds EX/MEM (0x504 from JALR)
    vecs[0] = vecs[18];
    vecs[0].pc = 32'h2000;
    vecs[0].imm = 32'h4;
    drive_vec(vecs[0]);
    bus.stall = 1'b1;
    #1;
    chk("stall_jal_taken", {31'd0, bus.branch_taken}, 32'd0);
    tick();
    chk("stall_hold", bus.ex_mem_out.alu_result, 32'h504);
    bus.stall = 1'b0;
    #1;
    chk("unstall_jal_taken", {31'd0, bus.branch_taken}, 32'd1);
    tick();
    chk("unstall_jal_result", bus.ex_mem_out.alu_result, 32'h2004);
    drive_bubble();

    // Multiply / divide: full iterations and fast paths
    run_md("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_md("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_md("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("rem_by0", MD_REM, 32'd5, 32'd0, 32'd5, 1);

    // Flush at BUSY count 10 aborts the op
    drive_md(MD_DIVU, 32'd1000, 32'd3);
    tick();
    repeat (10) tick();
    bus.flush = 1'b1;
    drive_bubble();
    tick();
    chk("flush_busy", {31'd0, bus.ex_busy}, 32'd0);
    chk("flush_exmem_zero", 32'(bus.ex_mem_out == '0), 32'd1);
    bus.flush = 1'b0;
    run_md("divu_after_flush", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Stall held three cycles in DONE
    drive_md(MD_DIVU, 32'd100, 32'd7);
    #1;
    n = 0;
    while (bus.ex_busy && n < 100) begin
      n++;
      tick();
    end
    chk("stall_done_busy_cycles", 32'(n), 32'd33);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_done_busy", {31'd0, bus.ex_busy}, 32'd0);
      chk("stall_done_hold", bus.ex_mem_out.alu_result, 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_done_capture", bus.ex_mem_out.alu_result, 32'd14);
    drive_bubble();
    tick();

    // Reset in the middle of BUSY
    drive_md(MD_MUL, 32'd3, 32'd5);
    repeat (5) tick();
    rst = 1'b1;
    drive_bubble();
    tick();
    chk("rst_mid_busy", {31'd0, bus.ex_busy}, 32'd0);
    chk("rst_mid_taken", {31'd0, bus.branch_taken}, 32'd0);
    chk("rst_mid_exmem_zero", 32'(bus.ex_mem_out == '0), 32'd1);
    rst = 1'b0;
    tick();
    run_md("remu_after_rst", MD_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage RV32IM pipeline, sitting between the ID/EX register and the MEM stage. Selects forwarded operands and computes the ALU result. Resolves branches and jumps, and runs M-extension ops in an iterative multiply/divide unit that holds the pipeline while busy. Owns the EX/MEM pipeline register (ex_mem_t), which feeds the data-memory request logic downstream.

Parameters:
ENABLE_M, 1, when 0: M-ops give result 0, complete in one cycle, never assert ex_busy
XLEN, 32, datapath width; must match riscv_pkg xlen_t

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
id_ex_in  input  id_ex_t  ID/EX register contents: pc, instr, rs1_data, rs2_data, imm, rd, ctrl
fwd_a_sel  input  2  operand A select: 00 rs1_data, 01 ex_mem_fwd, 10 wb_fwd, 11 rs1_data
fwd_b_sel  input  2  operand B select, same encoding, applied to rs2_data
ex_mem_fwd  input  XLEN  EX/MEM alu_result forwarded from the hazard unit
wb_fwd  input  XLEN  writeback data forwarded from WB
stall  input  1  hold the EX/MEM register
flush  input  1  zero the EX/MEM register and abort any M-op
ex_busy  output  1  M-op in progress; hazard unit stalls IF/ID/EX
branch_taken  output  1  redirect request
branch_target  output  XLEN  redirect PC
ex_mem_out  output  ex_mem_t  EX/MEM register: pc, instr, alu_result, rs2_data (forwarded B), rd, ctrl

Behaviour:
- Operands:
  - opA = fwd_a mux, or pc when ctrl.alu_src_a=PC.
  - opB = fwd_b mux, or imm when ctrl.alu_src_b=IMM.
  - ex_mem_out.rs2_data always takes the forwarded B value, not imm.
- ALU ops (ctrl.alu_op): ADD SUB SLL SRL SRA (shift amount = opB[4:0]), SLT SLTU XOR OR AND, PASS_B (LUI). All results are XLEN-wide and wrap modulo 2^XLEN.
- Branches (ctrl.branch, funct3 = instr[14:12]): BEQ BNE BLT BGE BLTU BGEU. Target = pc+imm.
- JAL: target pc+imm. JALR: target (opA+imm) & ~1. Both jumps write alu_result = pc+4.
- branch_taken is combinational. It is asserted when (jump | branch condition true) & !stall & !ex_busy. It is 0 for a bubble (all-zero ctrl).
- M unit FSM, sub-module md_unit (MUL MULH MULHSU MULHU DIV DIVU REM REMU):
  - IDLE: a valid M-op in id_ex_in latches operands and signs.
    - Divisor==0 or signed overflow goes to DONE in the next cycle.
    - Otherwise goes to BUSY with count=0.
  - BUSY: one shift-add or restoring-divide step per cycle. Moves to DONE after XLEN cycles.
  - DONE: result is valid. ex_busy=0 and the result is captured into EX/MEM, then the FSM returns to IDLE. If stall=1, it holds DONE.
  - ex_busy=1 from the first cycle the M-op is in EX through the last BUSY cycle. Normal latency is XLEN+2 cycles in EX (34 for XLEN=32); the fast path takes 2.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (INT_MIN / -1): quotient = INT_MIN, remainder = 0.
  - Operands are latched in IDLE, so forwarding changes during BUSY have no effect.
- EX/MEM register priority: rst -> '0; flush -> '0; stall -> hold; ex_busy -> bubble ('0); else capture.
- flush or rst during BUSY/DONE: FSM returns to IDLE next cycle, ex_busy=0, and the partial result is discarded.
- Reset values: ex_mem_out='0, FSM=IDLE, ex_busy=0. branch_taken=0 because a reset ID/EX is a bubble.

Decomposition:
- riscv_pkg gains:
  - id_ex_t
  - alu_op_e
  - md_op_e
  - fwd_sel_e (FWD_REG, FWD_MEM, FWD_WB)
  - ctrl_t fields alu_src_a, alu_src_b, branch, jump, jalr, md_en, md_op
  - the funct3 branch constants
- One sub-module, md_unit (FSM, counter, accumulator/remainder registers, sign fix-up). The ALU and branch compare stay inline.

Test Plan:
- ADD with fwd_a_sel=01, ex_mem_fwd=0x10, opB=0x22 -> ex_mem_out.alu_result=0x32 one cycle later; fwd_b_sel=10 with wb_fwd=7 -> rs2_data=7.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> branch_taken=1, target=0x120. Same operands with BLTU -> branch_taken=0. JALR with opA=0x203, imm=0 -> target=0x202, alu_result=pc+4.
- MULH 0x80000000 * 0x80000000 -> ex_busy high 33 cycles, result 0x40000000 captured in cycle 34, bubbles in EX/MEM before it.
- DIV 0x80000000 / 0xFFFFFFFF -> fast path, quotient 0x80000000. DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. Each takes 2 cycles.
- flush asserted at BUSY count=10 -> ex_busy=0 next cycle, ex_mem_out='0, and the next DIVU 100/7 gives 14 after the full latency.
- stall held 3 cycles while in DONE -> result held, EX/MEM captures it on the first !stall edge. rst mid-BUSY -> all outputs zero next cycle.
